// File: rtl/wb_regfile_if.sv
// MEM/WB writeback bus: pipeline-register inputs, decode read ports and
// EX forwarding/commit-count outputs of the register file.
interface wb_regfile_if #(
  parameter int DW = 32,
  parameter int AW = 5,
  parameter int CW = 16
);
  logic          en;
  logic          regwrt;
  logic          memtoreg;
  logic [AW-1:0] regdst;
  logic [DW-1:0] data;
  logic [DW-1:0] r;
  logic [AW-1:0] rs_addr;
  logic [AW-1:0] rt_addr;
  logic [DW-1:0] rs_data;
  logic [DW-1:0] rt_data;
  logic          fwd_valid;
  logic [AW-1:0] fwd_addr;
  logic [DW-1:0] fwd_value;
  logic [CW-1:0] wr_cnt;

  modport master (
    output en, regwrt, memtoreg, regdst, data, r, rs_addr, rt_addr,
    input  rs_data, rt_data, fwd_valid, fwd_addr, fwd_value, wr_cnt
  );
  modport slave (
    input  en, regwrt, memtoreg, regdst, data, r, rs_addr, rt_addr,
    output rs_data, rt_data, fwd_valid, fwd_addr, fwd_value, wr_cnt
  );
endinterface

// File: rtl/wb_regfile.sv
// Writeback register file: commits MEM/WB results, serves two bypassed
// decode read ports, and exposes the last commit as an EX forwarding source.
module wb_regfile #(
  parameter int DW = 32,
  parameter int AW = 5,
  parameter int CW = 16
) (
  input  logic         ck,
  input  logic         rst,
  wb_regfile_if.slave  bus
);
  localparam int NREG = 1 << AW;
  localparam int NRD  = 2;

  logic [DW-1:0] regs [NREG];
  logic [DW-1:0] wb_value;
  logic          wr_fire;
  logic          fwd_valid_q;
  logic [AW-1:0] fwd_addr_q;
  logic [DW-1:0] fwd_value_q;
  logic [CW-1:0] cnt_q;

  assign wb_value = bus.memtoreg ? bus.data : bus.r;
  // rst masks the commit so bypass is also off while reset is held
  assign wr_fire  = bus.en & bus.regwrt & (bus.regdst != '0) & ~rst;

  always_ff @(posedge ck) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      fwd_valid_q <= 1'b0;
      fwd_addr_q  <= '0;
      fwd_value_q <= '0;
      cnt_q       <= '0;
    end else begin
      fwd_valid_q <= wr_fire;
      if (wr_fire) begin
        regs[bus.regdst] <= wb_value;
        fwd_addr_q       <= bus.regdst;
        fwd_value_q      <= wb_value;
        cnt_q            <= cnt_q + CW'(1);
      end
    end
  end

  logic [AW-1:0] raddr [NRD];
  logic [DW-1:0] rdata [NRD];
  assign raddr[0] = bus.rs_addr;
  assign raddr[1] = bus.rt_addr;

  // Index 0 wins over bypass so $zero can never leak a value
  for (genvar p = 0; p < NRD; p++) begin : g_rd
    assign rdata[p] = (raddr[p] == '0)                       ? '0 :
                      (wr_fire && (bus.regdst == raddr[p]))  ? wb_value :
                                                               regs[raddr[p]];
  end

  assign bus.rs_data   = rdata[0];
  assign bus.rt_data   = rdata[1];
  assign bus.fwd_valid = fwd_valid_q;
  assign bus.fwd_addr  = fwd_addr_q;
  assign bus.fwd_value = fwd_value_q;
  assign bus.wr_cnt    = cnt_q;
endmodule

// File: tb/tb_wb_regfile.sv
// Randomised + directed bench for wb_regfile against an array-based model;
// a second instance with a 4-bit counter exercises wrap-around.
module tb_wb_regfile;
  logic ck = 1'b0;
  logic rst;
  always #5 ck = ~ck;

  wb_regfile_if #(.DW(32), .AW(5), .CW(16)) bus  ();
  wb_regfile_if #(.DW(32), .AW(5), .CW(4))  bus4 ();

  assign bus4.en       = bus.en;
  assign bus4.regwrt   = bus.regwrt;
  assign bus4.memtoreg = bus.memtoreg;
  assign bus4.regdst   = bus.regdst;
  assign bus4.data     = bus.data;
  assign bus4.r        = bus.r;
  assign bus4.rs_addr  = bus.rs_addr;
  assign bus4.rt_addr  = bus.rt_addr;

  wb_regfile #(.DW(32), .AW(5), .CW(16)) u_dut  (.ck(ck), .rst(rst), .bus(bus));
  wb_regfile #(.DW(32), .AW(5), .CW(4))  u_dut4 (.ck(ck), .rst(rst), .bus(bus4));

  int n_chk = 0;
  int n_err = 0;

  // reference state
  logic [31:0] m_regs [32];
  logic        m_fv;
  logic [4:0]  m_fa;
  logic [31:0] m_fd;
  int          m_commits;
  bit          m_init = 0;

  logic [31:0] last_rs, last_rt, last_fd, last_cnt, last_cnt4;
  logic [4:0]  last_fa;
  logic        last_fv;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_rd(input logic [4:0] a, input logic fire,
                                         input logic [4:0] d, input logic [31:0] v);
    if (a == 0) return 32'h0;
    if (fire && d == a) return v;
    return m_regs[a];
  endfunction

  // One clock: drive, check at negedge, advance the model at posedge
  task automatic step(input logic r_, input logic e, input logic w, input logic m,
                      input logic [4:0] d, input logic [31:0] ld, input logic [31:0] alu,
                      input logic [4:0] a, input logic [4:0] b);
    logic        fire;
    logic [31:0] v;
    rst = r_; bus.en = e; bus.regwrt = w; bus.memtoreg = m; bus.regdst = d;
    bus.data = ld; bus.r = alu; bus.rs_addr = a; bus.rt_addr = b;
    fire = e && w && (d != 0) && !r_;
    v    = m ? ld : alu;
    @(negedge ck);
    last_rs = bus.rs_data;  last_rt = bus.rt_data;
    last_fv = bus.fwd_valid; last_fa = bus.fwd_addr; last_fd = bus.fwd_value;
    last_cnt = 32'(bus.wr_cnt); last_cnt4 = 32'(bus4.wr_cnt);
    if (m_init) begin
      chk("rs_data",   last_rs, exp_rd(a, fire, d, v));
      chk("rt_data",   last_rt, exp_rd(b, fire, d, v));
      chk("fwd_valid", 32'(last_fv), 32'(m_fv));
      chk("fwd_addr",  32'(last_fa), 32'(m_fa));
      chk("fwd_value", last_fd, m_fd);
      chk("wr_cnt",    last_cnt,  32'(m_commits % 65536));
      chk("wr_cnt4",   last_cnt4, 32'(m_commits % 16));
      chk("rt4_data",  bus4.rt_data, exp_rd(b, fire, d, v));
    end
    @(posedge ck);
    if (r_) begin
      foreach (m_regs[i]) m_regs[i] = 32'h0;
      m_fv = 0; m_fa = 0; m_fd = 0; m_commits = 0; m_init = 1;
    end else begin
      m_fv = fire;
      if (fire) begin
        m_regs[d] = v; m_fa = d; m_fd = v; m_commits++;
      end
    end
    #1;
  endtask

  task automatic idle(input logic [4:0] a, input logic [4:0] b);
    step(0, 1, 0, 0, 5'd0, 32'h0, 32'h0, a, b);
  endtask

  initial begin
    rst = 1'b1;
    bus.en = 0; bus.regwrt = 0; bus.memtoreg = 0; bus.regdst = 0;
    bus.data = 0; bus.r = 0; bus.rs_addr = 0; bus.rt_addr = 0;

    // reset then read
    step(1, 0, 0, 0, 5'd0, 32'h0, 32'h0, 5'd0, 5'd0);
    idle(5'd5, 5'd31);
    chk("rst_rs", last_rs, 32'h0);
    chk("rst_rt", last_rt, 32'h0);
    chk("rst_fv", 32'(last_fv), 32'h0);
    chk("rst_cnt", last_cnt, 32'h0);

    // ALU writeback with same-cycle bypass
    step(0, 1, 1, 0, 5'd8, 32'hDEAD_BEEF, 32'h0000_1234, 5'd8, 5'd0);
    chk("byp_alu", last_rs, 32'h0000_1234);
    idle(5'd8, 5'd8);
    chk("fv_alu", 32'(last_fv), 32'h1);
    chk("fa_alu", 32'(last_fa), 32'd8);
    chk("fd_alu", last_fd, 32'h0000_1234);
    chk("cnt_alu", last_cnt, 32'd1);
    chk("arr_8", last_rs, 32'h0000_1234);

    // load writeback, dual-port hit, back-to-back commit
    step(0, 1, 1, 1, 5'd9, 32'hCAFE_F00D, 32'h1111_1111, 5'd9, 5'd9);
    chk("byp_ld_rs", last_rs, 32'hCAFE_F00D);
    chk("byp_ld_rt", last_rt, 32'hCAFE_F00D);
    step(0, 1, 1, 0, 5'd10, 32'h0, 32'h0000_00AA, 5'd9, 5'd10);
    chk("b2b_fa9", 32'(last_fa), 32'd9);
    idle(5'd10, 5'd9);
    chk("b2b_fv", 32'(last_fv), 32'h1);
    chk("b2b_fa10", 32'(last_fa), 32'd10);

    // $zero discard and stall
    step(0, 1, 1, 0, 5'd0, 32'h0, 32'hFFFF_FFFF, 5'd0, 5'd0);
    chk("zero_rd", last_rs, 32'h0);
    idle(5'd0, 5'd0);
    chk("zero_fv", 32'(last_fv), 32'h0);
    chk("zero_cnt", last_cnt, 32'd3);
    step(0, 0, 1, 0, 5'd12, 32'h0, 32'h7777_7777, 5'd12, 5'd12);
    chk("stall_byp", last_rs, 32'h0);
    idle(5'd12, 5'd0);
    chk("stall_arr", last_rs, 32'h0);
    chk("stall_fv", 32'(last_fv), 32'h0);

    // reset vs write collision
    step(1, 1, 1, 0, 5'd3, 32'h0, 32'h55, 5'd3, 5'd0);
    step(0, 1, 1, 0, 5'd3, 32'h0, 32'h55, 5'd3, 5'd0);
    chk("coll_cnt", last_cnt, 32'd0);
    chk("coll_fv", 32'(last_fv), 32'h0);
    idle(5'd3, 5'd0);
    chk("coll_r3", last_rs, 32'h55);

    // counter wrap on the 4-bit instance
    step(1, 0, 0, 0, 5'd0, 32'h0, 32'h0, 5'd0, 5'd0);
    for (int i = 0; i < 17; i++) begin
      step(0, 1, 1, 0, 5'((i % 31) + 1), 32'h0, 32'(i * 3 + 1), 5'd1, 5'd2);
      if (i == 15) chk("wrap15", last_cnt4, 32'd15);
      if (i == 16) chk("wrap0", last_cnt4, 32'd0);
    end
    idle(5'd0, 5'd0);
    chk("wrap1", last_cnt4, 32'd1);

    // randomised traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 99) < 3), ($urandom_range(0, 9) < 8), ($urandom_range(0, 9) < 7),
           1'($urandom), 5'($urandom), $urandom, $urandom, 5'($urandom), 5'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
